// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer around the program counter.
// It handshakes with instruction and data memory, picks the next PC and counts retired instructions.
module pc_sequencer #(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      pc_cur,
    output logic                 imem_req,
    input  logic                 imem_ack,
    output logic                 ir_load,
    input  logic                 is_jump,
    input  logic                 is_branch,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic                 is_halt,
    input  logic                 branch_taken,
    input  logic [XLEN-1:0]      target_addr,
    output logic                 dmem_req,
    input  logic                 dmem_ack,
    output logic                 rf_we,
    output logic                 updatePC,
    output logic [XLEN-1:0]      PCin,
    output logic [2:0]           state,
    output logic                 halted,
    output logic                 fault,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t                 r_state;
    logic [INSTRET_W-1:0]   r_instret;
    logic                   r_fault;

    logic                   w_redirect;
    logic                   w_misaligned;
    logic [XLEN-1:0]        w_pc_plus4;

    // Jump outranks branch, so a jump redirects regardless of branch_taken.
    assign w_redirect   = is_jump | (is_branch & branch_taken);
    assign w_misaligned = w_redirect & (target_addr[1:0] != 2'b00);
    assign w_pc_plus4   = pc_cur + XLEN'(4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
            r_fault   <= 1'b0;
        end else begin
            // updatePC marks the single retire cycle of every instruction.
            if (updatePC) r_instret <= r_instret + INSTRET_W'(1);
            case (r_state)
                S_FETCH:  if (imem_ack) r_state <= S_DECODE;
                S_DECODE: r_state <= is_halt ? S_HALT : S_EXEC;
                S_EXEC: begin
                    if (w_redirect) begin
                        if (w_misaligned) begin
                            r_fault <= 1'b1;
                            r_state <= S_HALT;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end else if (is_branch) begin
                        r_state <= S_FETCH;
                    end else if (is_load || is_store) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM:    if (dmem_ack) r_state <= is_load ? S_WB : S_FETCH;
                S_WB:     r_state <= S_FETCH;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Strobes are forced low while reset is held so outstanding requests drop at once.
    always_comb begin
        imem_req = 1'b0;
        ir_load  = 1'b0;
        dmem_req = 1'b0;
        rf_we    = 1'b0;
        updatePC = 1'b0;
        PCin     = '0;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_load  = imem_ack;
                end
                S_EXEC: begin
                    if (w_redirect) begin
                        if (!w_misaligned) begin
                            updatePC = 1'b1;
                            PCin     = target_addr;
                        end
                    end else if (is_branch) begin
                        updatePC = 1'b1;
                        PCin     = w_pc_plus4;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    if (dmem_ack && !is_load) begin
                        updatePC = 1'b1;
                        PCin     = w_pc_plus4;
                    end
                end
                S_WB: begin
                    rf_we    = 1'b1;
                    updatePC = 1'b1;
                    PCin     = w_pc_plus4;
                end
                default: ;
            endcase
        end
    end

    assign state   = r_state;
    assign halted  = (r_state == S_HALT);
    assign fault   = r_fault;
    assign instret = r_instret;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each step drives inputs after a rising edge and
// checks outputs against hand-computed values before the next edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_cur = '0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic        ir_load;
    logic        is_jump = 1'b0;
    logic        is_branch = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic        is_halt = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] target_addr = '0;
    logic        dmem_req;
    logic        dmem_ack = 1'b0;
    logic        rf_we;
    logic        updatePC;
    logic [31:0] PCin;
    logic [2:0]  state;
    logic        halted;
    logic        fault;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(.XLEN(32), .INSTRET_W(32)) dut (
        .clk(clk), .reset(reset), .pc_cur(pc_cur),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
        .is_jump(is_jump), .is_branch(is_branch), .is_load(is_load),
        .is_store(is_store), .is_halt(is_halt), .branch_taken(branch_taken),
        .target_addr(target_addr), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .updatePC(updatePC), .PCin(PCin), .state(state),
        .halted(halted), .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held low: everything quiet.
        #3;
        chk("rst_state", state, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_instret", instret, 0);
        chk("rst_fault", fault, 0);
        chk("rst_pcin", PCin, 0);
        tick();

        // ALU ops back to back with imem_ack tied high.
        reset = 1'b1; imem_ack = 1'b1; pc_cur = 32'h0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("alu_f_state", state, 0);
            chk("alu_f_req", imem_req, 1);
            chk("alu_f_irload", ir_load, 1);
            chk("alu_f_upd", updatePC, 0);
            tick();
            chk("alu_d_state", state, 1);
            chk("alu_d_req", imem_req, 0);
            tick();
            chk("alu_e_state", state, 2);
            chk("alu_e_upd", updatePC, 0);
            tick();
            chk("alu_wb_state", state, 4);
            chk("alu_wb_rfwe", rf_we, 1);
            chk("alu_wb_upd", updatePC, 1);
            chk("alu_wb_pcin", PCin, 32'h4);
            chk("alu_wb_instret", instret, i);
            tick();
        end
        chk("alu_instret3", instret, 3);
        chk("alu_back_fetch", state, 0);

        // Instruction memory acks after three wait cycles.
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("iwait_req", imem_req, 1);
            chk("iwait_irload", ir_load, 0);
            chk("iwait_state", state, 0);
            tick();
        end
        imem_ack = 1'b1;
        #1;
        chk("iack_req", imem_req, 1);
        chk("iack_irload", ir_load, 1);
        tick();
        chk("iack_decode", state, 1);
        chk("iack_irload_off", ir_load, 0);

        // Taken branch from 0x100 to 0x40.
        is_branch = 1'b1; branch_taken = 1'b1; pc_cur = 32'h100; target_addr = 32'h40;
        tick();
        chk("brt_state", state, 2);
        chk("brt_upd", updatePC, 1);
        chk("brt_pcin", PCin, 32'h40);
        chk("brt_rfwe", rf_we, 0);
        tick();
        chk("brt_fetch", state, 0);
        chk("brt_instret", instret, 4);

        // Not-taken branch: three cycles, falls through to pc+4.
        branch_taken = 1'b0;
        tick();
        tick();
        chk("brn_state", state, 2);
        chk("brn_upd", updatePC, 1);
        chk("brn_pcin", PCin, 32'h104);
        tick();
        chk("brn_fetch", state, 0);
        chk("brn_instret", instret, 5);

        // Load with two data-memory wait cycles.
        is_branch = 1'b0; is_load = 1'b1; pc_cur = 32'h200;
        tick();
        tick();
        chk("ld_exec_upd", updatePC, 0);
        chk("ld_exec_dreq", dmem_req, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("ld_mem_state", state, 3);
            chk("ld_mem_dreq", dmem_req, 1);
            chk("ld_mem_ireq", imem_req, 0);
            tick();
        end
        dmem_ack = 1'b1;
        #1;
        chk("ld_ack_dreq", dmem_req, 1);
        chk("ld_ack_upd", updatePC, 0);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("ld_wb_state", state, 4);
        chk("ld_wb_rfwe", rf_we, 1);
        chk("ld_wb_pcin", PCin, 32'h204);
        chk("ld_wb_dreq", dmem_req, 0);
        tick();
        chk("ld_instret", instret, 6);

        // Store with the same timing: PC updates from MEM, no register write.
        is_load = 1'b0; is_store = 1'b1;
        tick();
        tick();
        tick();
        chk("st_mem_state", state, 3);
        tick();
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("st_ack_upd", updatePC, 1);
        chk("st_ack_pcin", PCin, 32'h204);
        chk("st_ack_rfwe", rf_we, 0);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("st_fetch", state, 0);
        chk("st_instret", instret, 7);

        // pc+4 wraps at the top of the address space.
        is_store = 1'b0; pc_cur = 32'hFFFF_FFFC;
        tick();
        tick();
        tick();
        chk("wrap_upd", updatePC, 1);
        chk("wrap_pcin", PCin, 32'h0);
        tick();
        chk("wrap_instret", instret, 8);

        // Reset asserted while a load waits in MEM.
        is_load = 1'b1; pc_cur = 32'h300;
        tick();
        tick();
        tick();
        chk("rmid_dreq_before", dmem_req, 1);
        reset = 1'b0;
        #1;
        chk("rmid_dreq", dmem_req, 0);
        chk("rmid_state", state, 0);
        chk("rmid_instret", instret, 0);
        chk("rmid_upd", updatePC, 0);
        chk("rmid_ireq", imem_req, 0);
        tick();
        reset = 1'b1;
        #1;
        chk("rmid_release_state", state, 0);
        chk("rmid_release_ireq", imem_req, 1);

        // Jump to a misaligned target: fault and halt, nothing retires.
        is_load = 1'b0; is_jump = 1'b1; target_addr = 32'h42;
        tick();
        tick();
        chk("mis_exec_upd", updatePC, 0);
        chk("mis_exec_pcin", PCin, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("mis_state", state, 5);
            chk("mis_halted", halted, 1);
            chk("mis_fault", fault, 1);
            chk("mis_instret", instret, 0);
            chk("mis_ireq", imem_req, 0);
            tick();
        end

        // Reset clears the fault; a halt instruction then parks without one.
        reset = 1'b0;
        #1;
        chk("hrst_fault", fault, 0);
        chk("hrst_halted", halted, 0);
        tick();
        reset = 1'b1; is_jump = 1'b0; is_halt = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("halt_state", state, 5);
            chk("halt_halted", halted, 1);
            chk("halt_fault", fault, 0);
            chk("halt_upd", updatePC, 0);
            chk("halt_ireq", imem_req, 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control FSM that sequences instruction execution around the program counter register.
- Handshakes with instruction and data memory, and issues instruction-register load and register-file write strobes.
- Chooses the next PC (PC+4 or branch/jump target) and pulses updatePC exactly once per retired instruction.
- Sits between the decoder/ALU flags and the program_counter register; also keeps a retired-instruction counter.

Parameters:
XLEN, 32, datapath/address width.
INSTRET_W, 32, width of retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
pc_cur  input  XLEN  current PC value from the program counter.
imem_req  output  1  instruction fetch request.
imem_ack  input  1  instruction memory ready; ins valid this cycle.
ir_load  output  1  latch ins into the instruction register.
is_jump  input  1  decoded jump.
is_branch  input  1  decoded conditional branch.
is_load  input  1  decoded load.
is_store  input  1  decoded store.
is_halt  input  1  decoded halt instruction.
branch_taken  input  1  ALU branch condition, valid in EXEC.
target_addr  input  XLEN  branch/jump target, valid in EXEC.
dmem_req  output  1  data memory request.
dmem_ack  input  1  data memory access complete.
rf_we  output  1  register-file write enable.
updatePC  output  1  PC load strobe.
PCin  output  XLEN  next PC value.
state  output  3  current FSM state, for debug/verification.
halted  output  1  in HALT state.
fault  output  1  misaligned target captured; sticky until reset.
instret  output  INSTRET_W  count of retired instructions.

Behaviour:
- Reset (reset=0): immediately, asynchronously
  - state=FETCH; instret=0; fault=0.
  - All strobes 0 and PCin=0 while reset is low.
- Reset release: first clock with reset=1 is in FETCH with imem_req=1.
- Reset mid-operation: abandons any outstanding memory request the same instant; no partial update, no instret increment.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Strobe outputs are combinational from state and inputs. Counters and fault are registered.
- PCin=0 whenever updatePC=0.
- FETCH:
  - imem_req=1, held until imem_ack is sampled high.
  - On the ack cycle: ir_load=1, next state DECODE.
  - No timeout.
- DECODE: one cycle.
  - is_halt=1 -> HALT.
  - Otherwise -> EXEC.
- Flag priority in EXEC: jump > branch > load > store > ALU op (default).
- EXEC:
  - Jump, or branch with branch_taken=1: updatePC=1, PCin=target_addr, instret+1, next FETCH.
  - Branch not taken: updatePC=1, PCin=pc_cur+4, instret+1, next FETCH.
  - Load or store: next MEM.
  - ALU op: next WB.
- Misaligned target: if a taken jump/branch has target_addr[1:0]!=0, then updatePC=0, fault<=1, next HALT, no instret increment.
- MEM:
  - dmem_req=1, held until dmem_ack.
  - On ack with store: updatePC=1, PCin=pc_cur+4, instret+1, next FETCH.
  - On ack with load: next WB.
  - Flags must be held stable by the decoder for the whole instruction.
- WB: one cycle. rf_we=1, updatePC=1, PCin=pc_cur+4, instret+1, next FETCH.
- HALT: halted=1, all strobes 0. Exits only via reset.
- Arithmetic:
  - pc_cur+4 is modulo 2^XLEN: 0xFFFFFFFC -> 0x00000000, no flag.
  - instret wraps from all-ones to 0.
- Latency: ALU op = 4 cycles minimum; branch/jump = 3; store = 4; load = 5. Each memory wait cycle adds 1.
- Invariants:
  - updatePC is high for at most one cycle per instruction.
  - imem_req and dmem_req are never high together.
  - rf_we is high only in WB.

Test Plan:
- Reset release with pc_cur=0x0, imem_ack tied 1, ALU ops only -> updatePC pulses every 4 cycles with PCin=0x4; instret=3 after 12 cycles.
- imem_ack delayed 3 cycles -> imem_req stays high for 4 cycles; ir_load is a single pulse on the ack cycle; DECODE follows.
- Branch, pc_cur=0x100, target=0x40: branch_taken=1 -> PCin=0x40 in EXEC. branch_taken=0 -> PCin=0x104. Both take 3 cycles.
- Load, dmem_ack after 2 wait cycles -> dmem_req high 3 cycles, then WB with rf_we=1 and PCin=pc_cur+4. Store with the same timing -> no rf_we, PC updated in MEM.
- Jump to 0x42 -> fault=1, halted=1, state=5, no updatePC, instret unchanged. is_halt -> HALT with fault=0. Both stay put until reset.
- pc_cur=0xFFFFFFFC ALU op -> PCin=0x0. Assert reset low mid-MEM -> dmem_req drops the same instant, instret=0, FETCH after release.
